// File: rtl/ifid_skid_reg.sv
// ----------------------------------------------------------------------------
// ifid_skid_reg
//
// IF/ID pipeline register with a two-entry skid buffer. Fetch pushes
// {pc, instr} pairs with a valid/ready handshake and decode pops them the same
// way. Entries leave in strict FIFO order. A flush squashes every entry, and
// the decode side sees NOP_INSTR whenever no valid entry is held. The hazard
// unit's stall flag is passed through one register stage.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   fetch presents a valid PC/instruction
//   in_ready   buffer can accept an entry this cycle (depends on state only)
//   in_pc      PC+2 from fetch
//   in_instr   fetched instruction
//   out_valid  head entry is valid
//   out_ready  decode consumes the head entry this cycle
//   out_pc     head entry PC
//   out_instr  head entry instruction, or NOP_INSTR when out_valid is low
//   flush      synchronous squash of all entries
//   stall_in   stall flag from the hazard unit
//   stall_out  stall_in delayed by one clock
//   occupancy  number of valid entries, 0..2
// ----------------------------------------------------------------------------
module ifid_skid_reg #(
  parameter int unsigned          PC_W      = 16,
  parameter int unsigned          INSTR_W   = 16,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 16'h0800
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               flush,
  input  logic               stall_in,
  output logic               stall_out,
  output logic [1:0]         occupancy
);

  // The state encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_r;
  logic [PC_W-1:0]    head_pc_r;
  logic [INSTR_W-1:0] head_instr_r;
  logic [PC_W-1:0]    skid_pc_r;
  logic [INSTR_W-1:0] skid_instr_r;
  logic               stall_r;

  logic               push_s;
  logic               pop_s;

  // Handshake decode: in_ready comes only from the state register, so no
  // combinational path runs from out_ready or in_valid to in_ready.
  always_comb begin
    in_ready  = (state_r != FULL);
    out_valid = (state_r != EMPTY);
    push_s    = in_valid & in_ready;
    pop_s     = out_valid & out_ready;
  end

  // Output presentation: stale head data is masked with NOP when invalid.
  always_comb begin
    out_pc    = head_pc_r;
    occupancy = state_r;
    stall_out = stall_r;
    if (out_valid) begin
      out_instr = head_instr_r;
    end else begin
      out_instr = NOP_INSTR;
    end
  end

  // Buffer state machine, storage and stall passthrough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= EMPTY;
      head_pc_r    <= '0;
      head_instr_r <= NOP_INSTR;
      skid_pc_r    <= '0;
      skid_instr_r <= NOP_INSTR;
      stall_r      <= 1'b0;
    end else begin
      stall_r <= stall_in;
      if (flush) begin
        // Same-cycle push is dropped; data registers keep stale contents.
        state_r <= EMPTY;
      end else begin
        case (state_r)
          EMPTY: begin
            if (push_s) begin
              state_r      <= ONE;
              head_pc_r    <= in_pc;
              head_instr_r <= in_instr;
            end else begin
              state_r <= EMPTY;
            end
          end
          ONE: begin
            if (push_s && pop_s) begin
              // Head is consumed and replaced in the same cycle.
              head_pc_r    <= in_pc;
              head_instr_r <= in_instr;
            end else if (push_s) begin
              state_r      <= FULL;
              skid_pc_r    <= in_pc;
              skid_instr_r <= in_instr;
            end else if (pop_s) begin
              state_r <= EMPTY;
            end else begin
              state_r <= ONE;
            end
          end
          FULL: begin
            // No push can arrive here because in_ready is low.
            if (pop_s) begin
              state_r      <= ONE;
              head_pc_r    <= skid_pc_r;
              head_instr_r <= skid_instr_r;
            end else begin
              state_r <= FULL;
            end
          end
          default: begin
            state_r <= EMPTY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifid_skid_reg.sv
module tb_ifid_skid_reg;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic        flush;
  logic        stall_in;
  logic        stall_out;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;

  // Reference model: a FIFO of {pc, instr}, capacity 2.
  logic [31:0] q[$];
  logic [15:0] last_pc;   // pc of the most recent head entry (visible when empty)
  logic        stall_m;

  ifid_skid_reg #(.PC_W(16), .INSTR_W(16), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .flush(flush), .stall_in(stall_in), .stall_out(stall_out), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    last_pc = 16'h0000;
    stall_m = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs against the model, advance model.
  // Entered and left at posedge+1.
  task automatic run_cycle(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                           input logic ordy, input logic fl, input logic st);
    logic        push;
    logic        pop;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
    in_valid = v; in_pc = pc; in_instr = ins;
    out_ready = ordy; flush = fl; stall_in = st;
    #2;
    exp_instr = (q.size() != 0) ? q[0][15:0] : NOP;
    exp_pc    = (q.size() != 0) ? q[0][31:16] : last_pc;
    checks++;
    if (in_ready !== (q.size() != 2)) begin
      errors++; $display("FAIL in_ready actual=%b expected=%b t=%0t", in_ready, (q.size() != 2), $time);
    end
    checks++;
    if (out_valid !== (q.size() != 0)) begin
      errors++; $display("FAIL out_valid actual=%b expected=%b t=%0t", out_valid, (q.size() != 0), $time);
    end
    checks++;
    if (out_instr !== exp_instr) begin
      errors++; $display("FAIL out_instr actual=%h expected=%h t=%0t", out_instr, exp_instr, $time);
    end
    checks++;
    if (out_pc !== exp_pc) begin
      errors++; $display("FAIL out_pc actual=%h expected=%h t=%0t", out_pc, exp_pc, $time);
    end
    checks++;
    if (occupancy !== 2'(q.size())) begin
      errors++; $display("FAIL occupancy actual=%0d expected=%0d t=%0t", occupancy, q.size(), $time);
    end
    checks++;
    if (stall_out !== stall_m) begin
      errors++; $display("FAIL stall_out actual=%b expected=%b t=%0t", stall_out, stall_m, $time);
    end
    push = v && (q.size() < 2);
    pop  = ordy && (q.size() > 0);
    if (fl) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({pc, ins});
    end
    if (q.size() != 0) last_pc = q[0][31:16];
    stall_m = st;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_pc = 16'h1234; in_instr = 16'h5678;
    out_ready = 1'b1; flush = 1'b0; stall_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, occupancy, stall_out} !== 5'b01000) begin
      errors++; $display("FAIL reset_ctrl actual=%b expected=01000", {out_valid, in_ready, occupancy, stall_out});
    end
    checks++;
    if (out_instr !== NOP || out_pc !== 16'h0000) begin
      errors++; $display("FAIL reset_data actual=%h/%h expected=0800/0000", out_instr, out_pc);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; stall_in = 1'b0;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset actual=%b/%h/%b expected=0/0800/1", out_valid, out_instr, in_ready);
    end
    repeat (2) run_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stream();
    logic [15:0] pcs [3] = '{16'h0002, 16'h0004, 16'h0006};
    logic [15:0] ins [3] = '{16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, pcs[i], ins[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_pc !== pcs[i] || out_instr !== ins[i] || occupancy !== 2'd1) begin
        errors++; $display("FAIL stream%0d actual=%h/%h/%0d expected=%h/%h/1",
                           i, out_pc, out_instr, occupancy, pcs[i], ins[i]);
      end
    end
    run_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_cycle(1'b1, 16'h0002, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 16'h0004, 16'hBBBB, 1'b0, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full actual=%0d/%b expected=2/0", occupancy, in_ready);
    end
    run_cycle(1'b1, 16'h0006, 16'hCCCC, 1'b0, 1'b0, 1'b0);   // C held off
    checks++;
    if (out_instr !== 16'hAAAA) begin
      errors++; $display("FAIL bp_head_a actual=%h expected=aaaa", out_instr);
    end
    run_cycle(1'b1, 16'h0006, 16'hCCCC, 1'b1, 1'b0, 1'b0);   // pop A
    checks++;
    if (out_instr !== 16'hBBBB) begin
      errors++; $display("FAIL bp_head_b actual=%h expected=bbbb", out_instr);
    end
    run_cycle(1'b1, 16'h0006, 16'hCCCC, 1'b1, 1'b0, 1'b0);   // pop B, push C
    checks++;
    if (out_instr !== 16'hCCCC || out_pc !== 16'h0006) begin
      errors++; $display("FAIL bp_head_c actual=%h/%h expected=cccc/0006", out_instr, out_pc);
    end
    run_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    run_cycle(1'b1, 16'h0010, 16'h1010, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 16'h0012, 16'h1212, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 16'h0014, 16'h1414, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({occupancy, out_valid, in_ready} !== 4'b0001 || out_instr !== NOP) begin
      errors++; $display("FAIL flush actual=%0d/%b/%b/%h expected=0/0/1/0800",
                         occupancy, out_valid, in_ready, out_instr);
    end
    run_cycle(1'b1, 16'h0016, 16'h1616, 1'b0, 1'b1, 1'b0);   // flush from EMPTY with push
    run_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    run_cycle(1'b1, 16'h0020, 16'h2020, 1'b0, 1'b0, 1'b1);
    run_cycle(1'b1, 16'h0022, 16'h2222, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0; stall_in = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, occupancy, stall_out} !== 5'b01000) begin
      errors++; $display("FAIL async_rst_ctrl actual=%b expected=01000", {out_valid, in_ready, occupancy, stall_out});
    end
    checks++;
    if (out_instr !== NOP || out_pc !== 16'h0000) begin
      errors++; $display("FAIL async_rst_data actual=%h/%h expected=0800/0000", out_instr, out_pc);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    run_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    logic st_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic fl_pat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, 16'h0030 + 16'(i), 16'h3000 + 16'(i), 1'b0, fl_pat[i], st_pat[i]);
      checks++;
      if (stall_out !== st_pat[i]) begin
        errors++; $display("FAIL stall%0d actual=%b expected=%b", i, stall_out, st_pat[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
                1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifid_skid_reg.md
Name: ifid_skid_reg

Overview:
- Parametrised IF/ID pipeline register with a 2-entry skid buffer.
- Replaces the single write-enable hold scheme with a valid/ready handshake on both sides.
- Adds flush-to-bubble and NOP injection for invalid slots, and keeps the registered stall passthrough.
- Sits between fetch and decode; fetch drives the input side, decode/hazard logic drives the output side.

Parameters:
PC_W, 16, width of PC field
INSTR_W, 16, width of instruction field
NOP_INSTR, 16'h0800, instruction presented on out_instr when no valid entry (width INSTR_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
in_valid  in  1  fetch presents a valid PC/instruction
in_ready  out  1  buffer can accept this cycle
in_pc  in  PC_W  PC+2 from fetch
in_instr  in  INSTR_W  fetched instruction
out_valid  out  1  decode-side entry valid
out_ready  in  1  decode consumes the head entry this cycle
out_pc  out  PC_W  head entry PC
out_instr  out  INSTR_W  head entry instruction, or NOP_INSTR when !out_valid
flush  in  1  synchronous squash of all entries (branch mispredict)
stall_in  in  1  stall flag from hazard unit
stall_out  out  1  registered stall_in
occupancy  out  2  number of valid entries, 0..2

Behaviour:
- Storage: head register {pc, instr} and skid register {pc, instr}, plus a 2-bit count. States: EMPTY (0), ONE (1), FULL (2).
- in_ready = (count != 2). It depends only on state, with no combinational path from out_ready or in_valid.
- out_valid = (count != 0).
- out_pc = head.pc. out_instr = out_valid ? head.instr : NOP_INSTR.
- occupancy = count.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Transitions at each rising clk edge, when no flush:
  - EMPTY: push → ONE, head <= in.
  - ONE: push & pop → ONE, head <= in. push only → FULL, skid <= in. pop only → EMPTY. Neither → hold.
  - FULL: pop → ONE, head <= skid. No pop → hold. push is impossible because in_ready = 0.
- Ordering is strict FIFO; no entry is lost or duplicated.
- out_ready while EMPTY has no effect.
- flush has highest priority: count <= 0 at the next edge, any same-cycle push is discarded, and any same-cycle pop still counts as consumed by decode. Next cycle out_instr = NOP_INSTR and in_ready = 1. Head/skid data may stay stale but is masked by out_instr.
- stall_out <= stall_in every edge. It is unaffected by flush, push or pop.
- Latency: push into EMPTY → out_valid = 1 on the following cycle.
- Throughput: 1 entry/cycle sustained while out_ready = 1.
- Reset (rst = 0, asynchronous, takes effect immediately, including mid-transfer):
  - count = 0, head.pc = skid.pc = 0, head.instr = skid.instr = NOP_INSTR, stall_out = 0.
  - Outputs during reset: out_valid = 0, out_instr = NOP_INSTR, out_pc = 0, occupancy = 0, in_ready = 1.
  - Inputs are ignored until the first edge after rst rises.
- Widths: count never exceeds 2 and never underflows. No arithmetic on pc/instr; they are passed bit-exact.

Test Plan:
1. Reset then idle: rst = 0 for 3 cycles, release → out_valid = 0, out_instr = 16'h0800, out_pc = 0, in_ready = 1, occupancy = 0, stall_out = 0.
2. Streaming: out_ready = 1, push pc 0x0002/0x0004/0x0006 with instr 0x1111/0x2222/0x3333 on consecutive cycles → each appears on out_* exactly one cycle after push, occupancy stays 1.
3. Backpressure: out_ready = 0, push A (0x0002, 0xAAAA) then B (0x0004, 0xBBBB) → occupancy = 2, in_ready = 0, C held off. Raise out_ready → A, then B, then C in order, none dropped.
4. Flush while FULL with in_valid = 1 → next cycle occupancy = 0, out_valid = 0, out_instr = 16'h0800, in_ready = 1, pushed entry absent.
5. Async reset mid-operation: FULL, assert rst between clock edges → outputs go to reset values immediately without a clock edge.
6. stall_in pulse 1-0-1 during flush and push activity → stall_out reproduces the same pattern delayed by exactly one cycle.
